// File: rtl/csr_counter_bank.sv
// Machine counter CSR bank: mcycle, minstret and mhpmcounter3.. with
// mcountinhibit gating, sticky overflow status and read-only shadows.
module csr_counter_bank #(
  parameter int CNT_W = 64,
  parameter int N_HPM = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_ren,
  input  logic [11:0]      csr_raddr,
  output logic [31:0]      csr_rdata,
  input  logic             csr_wen,
  input  logic [11:0]      csr_waddr,
  input  logic [31:0]      csr_wdata,
  input  logic [1:0]       csr_op,
  input  logic             inst_done,
  input  logic [N_HPM-1:0] hpm_event,
  output logic             csr_illegal,
  output logic             csr_wr_err
);

  // Counter k lives at address offset / status bit 0 (k=0) or k+1 (k>=1).
  localparam int N_CNT = N_HPM + 2;
  localparam logic [31:0] BANK_MASK = 32'h1 | (((32'h1 << (N_HPM + 1)) - 32'h1) << 2);

  typedef struct packed {
    logic       mapped;
    logic       is_cnt;
    logic       is_inh;
    logic       is_ovf;
    logic       hi;
    logic [3:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [11:0] a);
    dec_t       d;
    logic [4:0] off;
    d   = '0;
    off = a[4:0];
    if (a == 12'h320) begin
      d.mapped = 1'b1;
      d.is_inh = 1'b1;
    end else if (a == 12'h7C0) begin
      d.mapped = 1'b1;
      d.is_ovf = 1'b1;
    end else if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
      if (off == 5'd0) begin
        d.mapped = 1'b1;
        d.idx    = 4'd0;
      end else if (off >= 5'd2 && int'(off) <= N_HPM + 2) begin
        d.mapped = 1'b1;
        d.idx    = 4'(off - 5'd1);
      end
      d.is_cnt = d.mapped;
      d.hi     = a[7];
    end
    return d;
  endfunction

  function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old,
                                           input logic [31:0] wd);
    case (op)
      2'b00:   return wd;
      2'b01:   return old | wd;
      default: return old & ~wd;
    endcase
  endfunction

  // High-half results are truncated to the counter width on the way back.
  function automatic logic [CNT_W-1:0] write_half(input logic [CNT_W-1:0] old, input logic hi,
                                                  input logic [1:0] op, input logic [31:0] wd);
    logic [63:0] w;
    w = 64'(old);
    if (hi) w[63:32] = apply_op(op, w[63:32], wd);
    else    w[31:0]  = apply_op(op, w[31:0], wd);
    return w[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt_q [N_CNT];
  logic [CNT_W-1:0] cnt_d [N_CNT];
  logic [31:0]      inhibit_q, inhibit_d;
  logic [31:0]      ovf_q, ovf_d;
  logic             wr_err_q, wr_err_d;

  dec_t             rdec, wdec;
  logic             wr_ok;
  logic [63:0]      rd_wide;
  logic [N_CNT-1:0] ev;
  logic [31:0]      wrap;
  logic [31:0]      ovf_clr;

  always_comb begin
    rdec      = decode(csr_raddr);
    rd_wide   = '0;
    for (int k = 0; k < N_CNT; k++) begin
      if (rdec.idx == 4'(k)) rd_wide = 64'(cnt_q[k]);
    end
    csr_rdata = '0;
    if (csr_ren && rdec.mapped) begin
      if (rdec.is_inh)      csr_rdata = inhibit_q;
      else if (rdec.is_ovf) csr_rdata = ovf_q;
      else if (rdec.hi)     csr_rdata = rd_wide[63:32];
      else                  csr_rdata = rd_wide[31:0];
    end
  end

  always_comb begin
    wdec        = decode(csr_waddr);
    wr_ok       = csr_wen && wdec.mapped && (csr_waddr[11:8] != 4'hC) && (csr_op != 2'b11);
    csr_illegal = (csr_ren && !rdec.mapped) || (csr_wen && !wr_ok);
    wr_err_d    = csr_wen && !wr_ok;

    ev   = {hpm_event, inst_done, 1'b1};
    wrap = '0;
    for (int k = 0; k < N_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      // A CSR write takes the place of this cycle's increment.
      if (wr_ok && wdec.is_cnt && wdec.idx == 4'(k)) begin
        cnt_d[k] = write_half(cnt_q[k], wdec.hi, csr_op, csr_wdata);
      end else if (ev[k] && !inhibit_q[(k == 0) ? 0 : k + 1]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
        wrap[(k == 0) ? 0 : k + 1] = &cnt_q[k];
      end
    end

    inhibit_d = inhibit_q;
    if (wr_ok && wdec.is_inh) inhibit_d = apply_op(csr_op, inhibit_q, csr_wdata) & BANK_MASK;

    ovf_clr = '0;
    if (wr_ok && wdec.is_ovf && csr_op != 2'b01) ovf_clr = csr_wdata;
    ovf_d = ((ovf_q & ~ovf_clr) | wrap) & BANK_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CNT; k++) cnt_q[k] <= '0;
      inhibit_q <= '0;
      ovf_q     <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < N_CNT; k++) cnt_q[k] <= cnt_d[k];
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign csr_wr_err = wr_err_q;

endmodule
